// File: rtl/aud_dsp_stream_if.sv
// rtl/aud_dsp_stream_if.sv - SRAM read handshake between the playback engine and recorder storage
interface aud_dsp_stream_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              o_sram_req;
  logic [ADDR_W-1:0] o_sram_addr;
  logic              i_sram_valid;
  logic [DATA_W-1:0] i_sram_data;

  modport master (
    output o_sram_req,
    output o_sram_addr,
    input  i_sram_valid,
    input  i_sram_data
  );

  modport slave (
    input  o_sram_req,
    input  o_sram_addr,
    output i_sram_valid,
    output i_sram_data
  );
endinterface

// File: rtl/aud_dsp_stream.sv
// rtl/aud_dsp_stream.sv - playback engine: SRAM fetch per DAC frame with speed modes, reverse and loop
module aud_dsp_stream #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20,
  parameter int SPD_W  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [1:0]        i_mode,
  input  logic [SPD_W-1:0]  i_speed,
  input  logic              i_reverse,
  input  logic              i_loop,
  input  logic              i_daclrck,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [ADDR_W-1:0] i_end_addr,
  aud_dsp_stream_if.master  sram,
  output logic [DATA_W-1:0] o_dac_data,
  output logic              o_finished,
  output logic              o_wrap
);

  // Product of (cur-prev) and the phase counter, wide enough for the signed quotient path.
  localparam int PW = DATA_W + SPD_W + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FETCH,
    S_PLAY,
    S_PAUSE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [1:0]        mode_q, mode_d;
  logic [SPD_W-1:0]  speed_q, speed_d;
  logic              rev_q, rev_d;
  logic              loop_q, loop_d;
  logic [SPD_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] cur_q, cur_d;
  logic [DATA_W-1:0] dac_q, dac_d;
  logic              req_q, req_d;
  logic              fin_q, fin_d;
  logic              wrap_q, wrap_d;
  logic              lrck_q, lrck_d;

  logic                 lr_rise;
  logic [SPD_W:0]       fac;
  logic signed [DATA_W:0] diff;
  logic signed [PW-1:0] diff_x, cnt_x, fac_x, prev_x, prod, quot, lin;
  logic [SPD_W:0]       step;
  logic                 hold_wrap;
  logic [ADDR_W:0]      addr_x, start_x, end_x, step_x, fwd_next, rev_next;
  logic                 hit;
  logic                 unused_bits;

  assign lr_rise = i_daclrck & ~lrck_q;

  // Linear interpolation between prev and cur at phase cnt/(speed+1), truncating toward zero.
  always_comb begin
    fac    = {1'b0, speed_q} + (SPD_W+1)'(1);
    diff   = $signed({cur_q[DATA_W-1], cur_q}) - $signed({prev_q[DATA_W-1], prev_q});
    diff_x = {{(PW-DATA_W-1){diff[DATA_W]}}, diff};
    cnt_x  = {{(PW-SPD_W){1'b0}}, cnt_q};
    fac_x  = {{(PW-SPD_W-1){1'b0}}, fac};
    prev_x = {{(PW-DATA_W){prev_q[DATA_W-1]}}, prev_q};
    prod   = diff_x * cnt_x;
    quot   = prod / fac_x;
    lin    = prev_x + quot;
  end

  // Address step for the current mode and boundary detection in one extra bit of headroom.
  always_comb begin
    hold_wrap = (cnt_q == speed_q);
    case (mode_q)
      2'd0:    step = (SPD_W+1)'(1);
      2'd1:    step = fac;
      default: step = hold_wrap ? (SPD_W+1)'(1) : '0;
    endcase
    addr_x   = {1'b0, addr_q};
    start_x  = {1'b0, start_q};
    end_x    = {1'b0, end_q};
    step_x   = {{(ADDR_W-SPD_W){1'b0}}, step};
    fwd_next = addr_x + step_x;
    rev_next = addr_x - step_x;
    hit      = rev_q ? (addr_x < (start_x + step_x)) : (fwd_next > end_x);
  end

  assign unused_bits = ^{lin[PW-1:DATA_W], rev_next[ADDR_W]};

  // Next-state and next-output computation for the playback FSM; stop overrides everything.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    start_d = start_q;
    end_d   = end_q;
    mode_d  = mode_q;
    speed_d = speed_q;
    rev_d   = rev_q;
    loop_d  = loop_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    dac_d   = dac_q;
    req_d   = req_q;
    fin_d   = fin_q;
    wrap_d  = 1'b0;
    lrck_d  = i_daclrck;

    case (state_q)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          state_d = S_WAIT;
          addr_d  = i_reverse ? i_end_addr : i_start_addr;
          cnt_d   = '0;
          prev_d  = '0;
          fin_d   = 1'b0;
        end
      end
      S_WAIT: begin
        if (lr_rise) begin
          state_d = S_FETCH;
          mode_d  = i_mode;
          speed_d = i_speed;
          rev_d   = i_reverse;
          loop_d  = i_loop;
          start_d = i_start_addr;
          end_d   = i_end_addr;
          req_d   = 1'b1;
        end
      end
      S_FETCH: begin
        if (sram.i_sram_valid && req_q) begin
          cur_d   = sram.i_sram_data;
          req_d   = 1'b0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        dac_d = (mode_q == 2'd3) ? lin[DATA_W-1:0] : cur_q;
        if (mode_q[1]) begin
          cnt_d = hold_wrap ? '0 : cnt_q + SPD_W'(1);
          if (mode_q == 2'd3 && hold_wrap) begin
            prev_d = cur_q;
          end
        end
        if (hit) begin
          if (loop_q) begin
            addr_d  = rev_q ? end_q : start_q;
            cnt_d   = '0;
            prev_d  = '0;
            wrap_d  = 1'b1;
            state_d = S_WAIT;
          end else begin
            fin_d   = 1'b1;
            addr_d  = '0;
            state_d = S_IDLE;
          end
        end else begin
          addr_d  = rev_q ? rev_next[ADDR_W-1:0] : fwd_next[ADDR_W-1:0];
          state_d = i_pause ? S_PAUSE : S_WAIT;
        end
      end
      S_PAUSE: begin
        dac_d = '0;
        if (i_start) begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (i_stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      dac_d   = '0;
      addr_d  = '0;
      req_d   = 1'b0;
      fin_d   = fin_q;
      wrap_d  = 1'b0;
      cnt_d   = cnt_q;
      prev_d  = prev_q;
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      start_q <= '0;
      end_q   <= '0;
      mode_q  <= '0;
      speed_q <= '0;
      rev_q   <= 1'b0;
      loop_q  <= 1'b0;
      cnt_q   <= '0;
      prev_q  <= '0;
      cur_q   <= '0;
      dac_q   <= '0;
      req_q   <= 1'b0;
      fin_q   <= 1'b0;
      wrap_q  <= 1'b0;
      lrck_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      start_q <= start_d;
      end_q   <= end_d;
      mode_q  <= mode_d;
      speed_q <= speed_d;
      rev_q   <= rev_d;
      loop_q  <= loop_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      dac_q   <= dac_d;
      req_q   <= req_d;
      fin_q   <= fin_d;
      wrap_q  <= wrap_d;
      lrck_q  <= lrck_d;
    end
  end

  assign sram.o_sram_req  = req_q;
  assign sram.o_sram_addr = addr_q;
  assign o_dac_data       = dac_q;
  assign o_finished       = fin_q;
  assign o_wrap           = wrap_q;

endmodule
